// File: rtl/modular_half_scaler_if.sv
// Handshake bundle for modular_half_scaler: input channel (din/shift_k) and
// output channel (dout), each with valid/ready, plus the sticky range flag.
interface modular_half_scaler_if #(
  parameter int DATA_WIDTH = 14,
  parameter int LANES      = 2,
  parameter int SHIFT_W    = 4
);
  // A channel transfers on the rising edge where valid && ready; the source
  // holds valid and its payload stable until that edge, ready may toggle freely.
  logic                        in_valid;
  logic                        in_ready;
  logic [LANES*DATA_WIDTH-1:0] din;
  logic [SHIFT_W-1:0]          shift_k;
  logic                        out_valid;
  logic                        out_ready;
  logic [LANES*DATA_WIDTH-1:0] dout;
  logic                        range_err;

  modport master (
    output in_valid, din, shift_k, out_ready,
    input  in_ready, out_valid, dout, range_err
  );

  modport slave (
    input  in_valid, din, shift_k, out_ready,
    output in_ready, out_valid, dout, range_err
  );
endinterface

// File: rtl/modular_half_scaler.sv
// Multi-lane iterative modular halver: y = x * 2^(-k) mod Q, one halving per cycle.
// Optional input range check/reduction enabled by defining MOD_HALF_RANGE_CHK_EN.
module modular_half_scaler #(
  parameter int DATA_WIDTH = 14,
  parameter int Q          = 12289,
  parameter int LANES      = 2,
  parameter int MAX_SHIFT  = 9,
  parameter int SHIFT_W    = $clog2(MAX_SHIFT + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  modular_half_scaler_if.slave  bus,
  output logic [1:0]            o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [DATA_WIDTH-1:0] H_W = DATA_WIDTH'((Q + 1) / 2);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_lane [LANES];
  logic [SHIFT_W-1:0]    r_cnt;
  logic [DATA_WIDTH-1:0] w_load [LANES];
  logic [SHIFT_W-1:0]    w_cnt_load;
  logic                  w_accept;

  // Odd x: (x + Q) / 2 == (x >> 1) + (Q + 1) / 2, which stays within DATA_WIDTH.
  function automatic logic [DATA_WIDTH-1:0] halve(input logic [DATA_WIDTH-1:0] x);
    return x[0] ? ((x >> 1) + H_W) : (x >> 1);
  endfunction

  assign w_accept   = bus.in_valid && (r_state == S_IDLE);
  assign w_cnt_load = (bus.shift_k > SHIFT_W'(MAX_SHIFT)) ? SHIFT_W'(MAX_SHIFT) : bus.shift_k;

`ifdef MOD_HALF_RANGE_CHK_EN
  localparam logic [DATA_WIDTH-1:0] Q_W = DATA_WIDTH'(Q);
  logic w_range_hit;
  logic r_range_err;

  // Inputs are required to be below 2Q, so one conditional subtraction reduces them.
  always_comb begin
    w_range_hit = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      w_load[i] = bus.din[i*DATA_WIDTH +: DATA_WIDTH];
      if (bus.din[i*DATA_WIDTH +: DATA_WIDTH] >= Q_W) begin
        w_load[i]   = bus.din[i*DATA_WIDTH +: DATA_WIDTH] - Q_W;
        w_range_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_range_err <= 1'b0;
    end else if (w_accept && w_range_hit) begin
      r_range_err <= 1'b1;
    end
  end

  assign bus.range_err = r_range_err;
`else
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_load[i] = bus.din[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign bus.range_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = (w_cnt_load == '0) ? S_DONE : S_RUN;
      S_RUN:  if (r_cnt == SHIFT_W'(1)) w_state_nxt = S_DONE;
      S_DONE: if (bus.out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      for (int i = 0; i < LANES; i++) r_lane[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt <= w_cnt_load;
            for (int i = 0; i < LANES; i++) r_lane[i] <= w_load[i];
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt - SHIFT_W'(1);
          for (int i = 0; i < LANES; i++) r_lane[i] <= halve(r_lane[i]);
        end
        default: ;
      endcase
    end
  end

  // Result is taken straight from the lane registers; nothing from din reaches dout.
  always_comb begin
    bus.in_ready  = (r_state == S_IDLE);
    bus.out_valid = (r_state == S_DONE);
    o_dbg_state   = r_state;
    bus.dout      = '0;
    for (int i = 0; i < LANES; i++) begin
      bus.dout[i*DATA_WIDTH +: DATA_WIDTH] = r_lane[i];
    end
  end

endmodule

// File: tb/tb_modular_half_scaler.sv
// Directed-vector bench for modular_half_scaler (Q=12289, 2 lanes, MAX_SHIFT=9).
module tb_modular_half_scaler;

  localparam int DW = 14;
  localparam int LN = 2;
  localparam int SW = 4;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  logic [LN*DW-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  modular_half_scaler_if #(.DATA_WIDTH(DW), .LANES(LN), .SHIFT_W(SW)) bus ();

  modular_half_scaler #(
    .DATA_WIDTH(DW), .Q(12289), .LANES(LN), .MAX_SHIFT(9), .SHIFT_W(SW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Waits for out_valid after an accept edge; lat counts edges up to the handshake edge.
  task automatic collect(input string tag, input int lat_exp);
    int lat;
    logic [LN*DW-1:0] e;
    lat = 1;
    @(negedge clk);
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, lat_exp);
    if (!bus.out_valid) begin
      exp_q.delete();
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "_dout_l0"}, bus.dout[0 +: DW], e[0 +: DW]);
    chk({tag, "_dout_l1"}, bus.dout[DW +: DW], e[DW +: DW]);
    if (bus.out_ready) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_post_out_valid"}, bus.out_valid, 0);
      chk({tag, "_post_in_ready"}, bus.in_ready, 1);
    end
  endtask

  task automatic run_vec(input logic [DW-1:0] a1, input logic [DW-1:0] a0, input logic [SW-1:0] k,
                         input logic [DW-1:0] e1, input logic [DW-1:0] e0,
                         input int lat_exp, input string tag);
    int b;
    b = 0;
    @(negedge clk);
    while (!bus.in_ready && b < 50) begin
      @(negedge clk);
      b++;
    end
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.din      = {a1, a0};
    bus.shift_k  = k;
    exp_q.push_back({e1, e0});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    collect(tag, lat_exp);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.din       = '0;
    bus.shift_k   = '0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_dout", bus.dout, 0);
    chk("rst_range_err", bus.range_err, 0);
    chk("rst_state", dbg_state, 0);

    run_vec(14'd3,     14'd1, 4'd1,  14'd6146, 14'd6145,  2, "k1");
    run_vec(14'd12288, 14'd1, 4'd9,  14'd24,   14'd12265, 10, "k9");
    run_vec(14'd3,     14'd0, 4'd2,  14'd3073, 14'd0,      3, "k2");
    run_vec(14'd7,     14'd5, 4'd0,  14'd7,    14'd5,      1, "k0");
    run_vec(14'd12288, 14'd1, 4'd15, 14'd24,   14'd12265, 10, "k15_sat");

    // backpressure: hold the result, offer a competing input meanwhile
    bus.out_ready = 1'b0;
    run_vec(14'd3, 14'd0, 4'd2, 14'd3073, 14'd0, 3, "bp");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_dout", bus.dout, {14'd3073, 14'd0});
      chk("bp_state", dbg_state, 2);
      if (i == 0) begin
        bus.in_valid = 1'b1;
        bus.din      = {14'd100, 14'd100};
        bus.shift_k  = 4'd1;
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_rel_out_valid", bus.out_valid, 0);
    chk("bp_rel_in_ready", bus.in_ready, 1);
    chk("bp_rel_dout_kept", bus.dout, {14'd3073, 14'd0});

    // reset in the middle of a k=9 run, with 4 halvings left
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.din      = {14'd12288, 14'd1};
    bus.shift_k  = 4'd9;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("mid_state_run", dbg_state, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_dout", bus.dout, 0);
    chk("mid_rst_state", dbg_state, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rel_in_ready", bus.in_ready, 1);
    run_vec(14'd2, 14'd2, 4'd1, 14'd1, 14'd1, 2, "after_rst");

    // out-of-range lane: 12290 reduces to 1 (checked) or halves raw to 6145 (unchecked)
    run_vec(14'd12290, 14'd1, 4'd1, 14'd6145, 14'd6145, 2, "range");
`ifdef MOD_HALF_RANGE_CHK_EN
    chk("range_err_set", bus.range_err, 1);
`else
    chk("range_err_set", bus.range_err, 0);
`endif
    run_vec(14'd3, 14'd1, 4'd1, 14'd6146, 14'd6145, 2, "range_next");
`ifdef MOD_HALF_RANGE_CHK_EN
    chk("range_err_sticky", bus.range_err, 1);
`else
    chk("range_err_sticky", bus.range_err, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
